// File: rtl/simon_seq_gen.sv
// simon_seq_gen: replayable pseudo-random colour sequence for a Simon-style game.
// A free-running Galois LFSR supplies seeds; a second LFSR, restarted from the
// stored seed, walks the elements of the current round.
module simon_seq_gen #(
  parameter int                LFSR_W    = 18,
  parameter logic [LFSR_W-1:0] POLY      = 18'h20400,
  parameter logic [LFSR_W-1:0] SEED_INIT = 18'h26AD7,
  parameter int                NUM_CH    = 4,
  parameter int                MAX_LEN   = 32,
  localparam int               SYM_W     = $clog2(NUM_CH),
  localparam int               IDX_W     = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              randomize,
  input  logic              start_over,
  input  logic              next,
  input  logic              grow,
  output logic [NUM_CH-1:0] seq,
  output logic [SYM_W-1:0]  seq_sym,
  output logic [IDX_W-1:0]  index,
  output logic [IDX_W-1:0]  length,
  output logic              last,
  output logic              full
);

  localparam logic [IDX_W-1:0] LEN_MAX = IDX_W'(MAX_LEN);
  localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);

  logic [LFSR_W-1:0] counter;
  logic [LFSR_W-1:0] seed;
  logic [LFSR_W-1:0] current;

  logic [LFSR_W-1:0] counter_nxt;
  logic [LFSR_W-1:0] seed_nxt;
  logic [LFSR_W-1:0] current_nxt;
  logic [IDX_W-1:0]  index_nxt;
  logic [IDX_W-1:0]  length_nxt;

  // One Galois shift: fold the polynomial back in when a 1 falls off the bottom.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] x);
    lfsr_step = x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
  endfunction

  // An element consumes SYM_W fresh bits, so it costs SYM_W shifts.
  function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] x);
    logic [LFSR_W-1:0] v;
    v = x;
    for (int i = 0; i < SYM_W; i++) begin
      v = lfsr_step(v);
    end
    lfsr_advance = v;
  endfunction

  // Next-state decode: randomize beats start_over beats next; grow is independent.
  always_comb begin
    counter_nxt = lfsr_step(counter);
    seed_nxt    = seed;
    current_nxt = current;
    index_nxt   = index;
    length_nxt  = length;
    if (randomize) begin
      // An all-zero LFSR would lock up, so never hand one out as a seed.
      seed_nxt    = (counter == '0) ? LFSR_W'(1) : counter;
      current_nxt = (counter == '0) ? LFSR_W'(1) : counter;
      index_nxt   = '0;
      length_nxt  = ONE;
    end else begin
      if (start_over) begin
        current_nxt = seed;
        index_nxt   = '0;
      end else if (next && (index < length - ONE)) begin
        current_nxt = lfsr_advance(current);
        index_nxt   = index + ONE;
      end
      if (grow && (length < LEN_MAX)) begin
        length_nxt = length + ONE;
      end
    end
  end

  // State registers; reset wins over every command and clears any replay.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      counter <= SEED_INIT;
      seed    <= SEED_INIT;
      current <= SEED_INIT;
      index   <= '0;
      length  <= ONE;
    end else begin
      counter <= counter_nxt;
      seed    <= seed_nxt;
      current <= current_nxt;
      index   <= index_nxt;
      length  <= length_nxt;
    end
  end

  // Outputs decode straight from the registered state.
  always_comb begin
    seq_sym = current[SYM_W-1:0];
    seq     = NUM_CH'(1) << seq_sym;
    last    = (index == length - ONE);
    full    = (length == LEN_MAX);
  end

endmodule

// File: tb/tb_simon_seq_gen.sv
// Testbench for simon_seq_gen: randomized commands against a reference model
// that derives each element directly from the stored seed and the position.
module tb_simon_seq_gen;

  localparam logic [17:0] POLY = 18'h20400;
  localparam logic [17:0] SEED = 18'h26AD7;
  localparam int MAXL = 32;

  logic clk = 1'b0;
  logic rst_n, randomize, start_over, next, grow;
  logic [3:0] seq;
  logic [1:0] seq_sym;
  logic [5:0] index, length;
  logic last, full;

  simon_seq_gen dut (
    .clk(clk), .rst_n(rst_n), .randomize(randomize), .start_over(start_over),
    .next(next), .grow(grow), .seq(seq), .seq_sym(seq_sym), .index(index),
    .length(length), .last(last), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] seq;
    logic [1:0] sym;
    logic [5:0] idx;
    logic [5:0] len;
    logic       last;
    logic       full;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  // Reference model state: abstract round (seed, position, length) plus counter.
  logic [17:0] m_cnt, m_seed;
  int m_idx, m_len;

  function automatic logic [17:0] step(input logic [17:0] x);
    step = x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
  endfunction

  // Element k of a round is the seed shifted 2*k times.
  function automatic logic [17:0] element(input logic [17:0] s, input int k);
    logic [17:0] v;
    v = s;
    for (int i = 0; i < 2 * k; i++) v = step(v);
    element = v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    logic [17:0] cur;
    cur = element(m_seed, m_idx);
    e.sym  = cur[1:0];
    e.seq  = 4'b0001 << cur[1:0];
    e.idx  = 6'(m_idx);
    e.len  = 6'(m_len);
    e.last = (m_idx == m_len - 1);
    e.full = (m_len == MAXL);
    return e;
  endfunction

  // Drive one cycle of commands, update the model for that edge, queue the result.
  task automatic cyc(input logic rs, input logic rnd, input logic so, input logic nx, input logic gr);
    @(negedge clk);
    rst_n = rs; randomize = rnd; start_over = so; next = nx; grow = gr;
    if (!rs) begin
      m_cnt = SEED; m_seed = SEED; m_idx = 0; m_len = 1;
    end else begin
      if (rnd) begin
        m_seed = (m_cnt == 0) ? 18'd1 : m_cnt;
        m_idx = 0; m_len = 1;
      end else begin
        if (so) m_idx = 0;
        else if (nx && m_idx < m_len - 1) m_idx++;
        if (gr && m_len < MAXL) m_len++;
      end
      m_cnt = step(m_cnt);
    end
    exp_q.push_back(model_out());
    @(posedge clk);
    #2;
  endtask

  // Monitor: every cycle the DUT presents a fresh state, compare it with the queue head.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{seq: seq, sym: seq_sym, idx: index, len: length, last: last, full: full};
        check("scoreboard", 64'(a), 64'(e));
      end
    end
  end

  initial begin
    int wait_cnt;
    logic [17:0] cnt_at_edge;
    rst_n = 1'b0; randomize = 1'b0; start_over = 1'b0; next = 1'b0; grow = 1'b0;

    // Reset held for two cycles.
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("reset_seq",   64'(seq),     64'(4'b1000));
    check("reset_sym",   64'(seq_sym), 64'(2'd3));
    check("reset_index", 64'(index),   64'd0);
    check("reset_len",   64'(length),  64'd1);
    check("reset_last",  64'(last),    64'd1);
    check("reset_full",  64'(full),    64'd0);

    // Grow then next.
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, 0);
    check("gn_len",   64'(length),      64'd2);
    check("gn_index", 64'(index),       64'd1);
    check("gn_cur",   64'(dut.current), 64'(18'h39CB5));
    check("gn_seq",   64'(seq),         64'(4'b0010));
    check("gn_last",  64'(last),        64'd1);
    cyc(1, 0, 0, 1, 0);
    check("gn_hold_index", 64'(index),       64'd1);
    check("gn_hold_cur",   64'(dut.current), 64'(18'h39CB5));

    // Replay from the start.
    cyc(1, 0, 1, 0, 0);
    check("replay_index", 64'(index), 64'd0);
    check("replay_seq",   64'(seq),   64'(4'b1000));
    check("replay_last",  64'(last),  64'd0);
    cyc(1, 0, 0, 1, 0);
    check("replay_next_seq", 64'(seq), 64'(4'b0010));

    // Saturation of length.
    for (int i = 0; i < MAXL + 3; i++) cyc(1, 0, 0, 0, 1);
    check("sat_len",  64'(length), 64'd32);
    check("sat_full", 64'(full),   64'd1);

    // Every command at once: randomize wins, captures the counter at that edge.
    cnt_at_edge = m_cnt;
    cyc(1, 1, 1, 1, 1);
    check("prio_seed",  64'(dut.seed),    64'(cnt_at_edge));
    check("prio_cur",   64'(dut.current), 64'(cnt_at_edge));
    check("prio_index", 64'(index),       64'd0);
    check("prio_len",   64'(length),      64'd1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 1, 0);

    // Reset in the middle of a replay.
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 0);
    check("mid_index", 64'(index), 64'd3);
    cyc(0, 0, 0, 1, 1);
    check("mid_rst_seq",   64'(seq),         64'(4'b1000));
    check("mid_rst_index", 64'(index),       64'd0);
    check("mid_rst_len",   64'(length),      64'd1);
    check("mid_rst_last",  64'(last),        64'd1);
    check("mid_rst_full",  64'(full),        64'd0);
    check("mid_rst_cnt",   64'(dut.counter), 64'(SEED));
    cyc(1, 0, 0, 0, 0);
    check("mid_rst_cnt_step", 64'(dut.counter), 64'(step(SEED)));

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      int r;
      logic rs, rnd, so, nx, gr;
      r   = $urandom_range(0, 999);
      rs  = (r >= 8);
      rnd = ($urandom_range(0, 99) < 4);
      so  = ($urandom_range(0, 99) < 10);
      nx  = ($urandom_range(0, 99) < 50);
      gr  = ($urandom_range(0, 99) < 25);
      cyc(rs, rnd, so, nx, gr);
    end

    // Drain the scoreboard with a bounded wait.
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    #3;
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
